// File: rtl/arb_pkg.sv
// Shared constants, state encoding and width helper for the N-requester arbiter.
package arb_pkg;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Like $clog2 but never returns 0, so a derived vector width stays legal.
   function automatic int clog2_safe(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first candidate at or after 'start', wrapping,
// with the 'excl' bits removed from the candidate set.
module arb_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = clog2_safe(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  start,
   input  logic [N_REQ-1:0] excl,
   output logic [N_REQ-1:0] win,
   output logic [ID_W-1:0]  win_id,
   output logic             any
);

   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] rot;
   logic             found;
   int               offset;

   // Rotating a doubled copy puts 'start' at bit 0, so a plain lowest-bit search wraps for free.
   always_comb begin
      cand   = req & ~excl;
      rot    = N_REQ'({cand, cand} >> start);
      found  = 1'b0;
      offset = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && rot[i]) begin
            found  = 1'b1;
            offset = i;
         end
      end
   end

   assign any    = found;
   assign win_id = ID_W'((int'(start) + offset) % N_REQ);
   assign win    = found ? (N_REQ'(1) << win_id) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// N-requester arbiter with runtime fixed-priority / round-robin selection and registered one-hot grants.
// Define ARB_HOLD_LIMIT_EN to cap how long one owner may hold the grant while others wait.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int  N_REQ    = 4,
   parameter int  MAX_HOLD = 4,
   localparam int ID_W     = clog2_safe(N_REQ)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             mode,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_id
);

   if (N_REQ < 2 || N_REQ > 32 || MAX_HOLD < 1) begin : g_bad_params
      $error("rr_arbiter: N_REQ must be 2..32 and MAX_HOLD >= 1");
   end

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

   arb_state_t       state, state_next;
   logic [ID_W-1:0]  ptr, ptr_next;
   logic [N_REQ-1:0] gnt_next;
   logic             valid_next;
   logic [ID_W-1:0]  id_next;
   logic [ID_W-1:0]  pick_start;
   logic [N_REQ-1:0] pick_win;
   logic [ID_W-1:0]  pick_id;
   logic             pick_any;
   logic             owner_req;
   logic             take_pick;
   logic             go_idle;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int              CNT_W    = clog2_safe(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   logic [CNT_W-1:0] hold_cnt, cnt_next;
`endif

   function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + ID_W'(1);
   endfunction

   assign owner_req  = |(req & gnt);
   assign pick_start = (mode == ARB_RR) ? ptr : '0;

   // The current owner is always excluded; it only matters when it is still requesting at the limit.
   arb_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req),
      .start  (pick_start),
      .excl   (gnt),
      .win    (pick_win),
      .win_id (pick_id),
      .any    (pick_any)
   );

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      gnt_next   = gnt;
      valid_next = gnt_valid;
      id_next    = gnt_id;
      take_pick  = 1'b0;
      go_idle    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_next   = hold_cnt;
`endif
      case (state)
         ARB_IDLE: begin
            take_pick = pick_any;
         end
         ARB_GRANT: begin
            if (!owner_req) begin
               take_pick = pick_any;
               go_idle   = !pick_any;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_cnt >= HOLD_MAX) begin
               if (pick_any) begin
                  take_pick = 1'b1;
               end else begin
                  cnt_next = CNT_W'(1);
                  ptr_next = next_idx(gnt_id);
               end
            end else begin
               cnt_next = hold_cnt + CNT_W'(1);
            end
`endif
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (take_pick) begin
         state_next = ARB_GRANT;
         gnt_next   = pick_win;
         valid_next = 1'b1;
         id_next    = pick_id;
         ptr_next   = next_idx(pick_id);
`ifdef ARB_HOLD_LIMIT_EN
         cnt_next   = CNT_W'(1);
`endif
      end else if (go_idle) begin
         state_next = ARB_IDLE;
         gnt_next   = '0;
         valid_next = 1'b0;
         id_next    = '0;
`ifdef ARB_HOLD_LIMIT_EN
         cnt_next   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         gnt       <= gnt_next;
         gnt_valid <= valid_next;
         gnt_id    <= id_next;
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= cnt_next;
      end
   end
`endif

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-requester arbiter that generalises the existing two-requester `arbiter` block. It supports runtime-selectable fixed-priority or round-robin arbitration, registered one-hot grants, and grant hold while the owner keeps requesting. It sits in front of any shared resource (bus port, memory bank, shared FIFO) and replaces the two-input arbiter wherever more than two masters compete.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, 4: maximum consecutive cycles one owner may hold the grant while others are pending; legal range ≥1. Only used with `ARB_HOLD_LIMIT_EN`.
- `ID_W`, `$clog2(N_REQ)`: width of `gnt_id`; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = fixed priority (index 0 highest), 1 = round-robin.
- `req` in N_REQ: request vector; bit i belongs to requester i.
- `gnt` out N_REQ: registered one-hot grant, or all-zero.
- `gnt_valid` out 1: high when `gnt` is non-zero.
- `gnt_id` out ID_W: index of the granted requester; 0 when `gnt_valid` = 0.

## Operation
- State machine with two states:
  - IDLE: no owner. Any `req` bit set leads to GRANT, with the owner chosen by the current `mode`.
  - GRANT: owner = `gnt_id`.
    - `req[owner]` = 0 and other requests pending: re-arbitrate and hand over at the same edge, with no idle cycle.
    - `req[owner]` = 0 and no requests: go to IDLE.
    - `req[owner]` = 1: hold the grant (subject to the hold limit, see Configuration).
- Fixed priority: the lowest set index wins.
- Round-robin: a pointer `ptr` holds the highest-priority index. The search runs from `ptr` upward with wrap-around. After each new grant to index i, `ptr` becomes (i+1) mod N_REQ, wrapping N_REQ-1 to 0.
- `ptr` advances in both modes, so switching to round-robin starts from a fair position.
- `mode` is sampled only at arbitration decisions. Changing it while a grant is held has no effect until the next decision.
- `gnt`, `gnt_valid` and `gnt_id` are mutually consistent registers, never derived combinationally from `req`.

## Timing
- Reset (async assert): `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `ptr` = 0, hold counter = 0, state = IDLE. Outputs clear immediately, without waiting for a clock edge.
- Reset deassertion is synchronised by the integrator. The first decision is on the first rising edge with `nreset` = 1.
- Latency: `req` sampled at edge k gives `gnt` valid after edge k. This is 1 cycle from request to grant.
- Release: owner drops `req` before edge k, so its `gnt` is low after edge k, and any new owner's `gnt` is high after the same edge k.
- Reset mid-grant: the grant drops asynchronously. After release, arbitration restarts from `ptr` = 0.
- Requests are level-sensitive. A requester deasserting before being granted is simply never granted; there is no queuing.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined: a hold counter of width `$clog2(MAX_HOLD+1)` counts consecutive owner cycles.
  - When the count reaches `MAX_HOLD` and any other request is pending, the owner is masked out for that one decision and the grant moves per `mode`.
  - When the count reaches `MAX_HOLD` and no other request is pending, the owner is re-granted with no bubble, the counter resets to 1, and `ptr` advances.
  - `MAX_HOLD` = 1 forces re-arbitration every cycle.
- `ARB_HOLD_LIMIT_EN` undefined: no counter. The owner holds the grant indefinitely while `req[owner]` = 1. `MAX_HOLD` is ignored.

## Structure
- Package `arb_pkg` holds:
  - the mode constants `ARB_FIXED` = 1'b0 and `ARB_RR` = 1'b1;
  - the state enum `ARB_IDLE` / `ARB_GRANT`;
  - a `clog2`-safe helper function for `ID_W`.
- Sub-module `arb_pick`: purely combinational. Inputs are the request vector, the start index and an exclude mask. Outputs are the one-hot winner, the winner index and an any-flag, found via a doubled-vector priority search.
- `rr_arbiter` owns all registers (state, `ptr`, counter, outputs).

## Test plan
All scenarios use `N_REQ` = 4 and `MAX_HOLD` = 4.
1. Reset: drive `req` = 4'b1111 with `nreset` = 0 → `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0. Assert `nreset` mid-grant → outputs clear before the next edge.
2. Fixed priority: `mode` = 0, `req` = 4'b1010 → `gnt` = 4'b0010 after one edge. Drop `req[1]` → `gnt` = 4'b1000 at the same edge as the drop is sampled.
3. Round-robin rotation (limit on): `mode` = 1, `req` = 4'b1111 held → owner sequence 0,1,2,3,0, each holding exactly 4 cycles.
4. Hold without limit (macro off): `req` = 4'b0011 held 20 cycles → `gnt` = 4'b0001 for all 20 cycles.
5. Lone owner at limit (macro on): `req` = 4'b0100 held 10 cycles → `gnt` = 4'b0100 continuously with no bubble, and `ptr` = 3 afterwards.
6. Mode switch mid-grant: owner 2 holding, `mode` toggled 0→1, `req` = 4'b1101 → owner 2 keeps the grant until it drops `req[2]`, then `gnt` = 4'b1000, per round-robin from `ptr` = 3.
